// File: rtl/demux1_3_buf_if.sv
// Handshake bundle between one source, the 1-to-3 demux and its three sinks.
// Latency: none (wires only).
// Backpressure: oReady toward the source, iSinkRdy[k] from each sink.
// Ports:
//   iValid/iS/iData  source word, route select, data
//   oReady           source handshake ready
//   oValid/iSinkRdy  per-channel valid and sink ready
//   oData0..2        per-channel data
//   oBusy            any channel occupied
interface demux1_3_buf_if #(
    parameter int WIDTH = 32
);
    logic             iValid;
    logic [1:0]       iS;
    logic [WIDTH-1:0] iData;
    logic             oReady;
    logic [2:0]       oValid;
    logic [2:0]       iSinkRdy;
    logic [WIDTH-1:0] oData0;
    logic [WIDTH-1:0] oData1;
    logic [WIDTH-1:0] oData2;
    logic             oBusy;

    // Source plus sinks side (drives the demux inputs).
    modport master (
        output iValid, iS, iData, iSinkRdy,
        input  oReady, oValid, oData0, oData1, oData2, oBusy
    );

    // Demux side.
    modport slave (
        input  iValid, iS, iData, iSinkRdy,
        output oReady, oValid, oData0, oData1, oData2, oBusy
    );
endinterface

// File: rtl/demux1_3_buf.sv
// Buffered 1-to-3 demux: routes a valid/ready source word by iS into one of three 1-entry registers.
// Latency: 1 cycle source to sink; 1 word/cycle per channel.
// Backpressure: oReady drops only when the selected channel is full and its sink is stalled.
// Ports:
//   iClk, iRst   clock and asynchronous active-high reset
//   bus          demux1_3_buf_if slave modport (source handshake, three sink channels, oBusy)
module demux1_3_buf #(
    parameter int WIDTH = 32
) (
    input logic           iClk,
    input logic           iRst,
    demux1_3_buf_if.slave bus
);

    logic [2:0]       valid_q;
    logic [2:0]       valid_d;
    logic [WIDTH-1:0] data_q [3];
    logic [WIDTH-1:0] data_d [3];

    logic [2:0] tgt_oh;
    logic [2:0] drain;
    logic       ready;
    logic       accept;

    always_comb begin
        // Select 2'b11 aliases onto channel 2, matching the 3:1 select default.
        tgt_oh = 3'b100;
        case (bus.iS)
            2'b00:   tgt_oh = 3'b001;
            2'b01:   tgt_oh = 3'b010;
            default: tgt_oh = 3'b100;
        endcase

        drain = valid_q & bus.iSinkRdy;

        // A full target can still accept when its sink drains it on the same edge.
        ready  = ((valid_q & tgt_oh) == 3'b000) || ((bus.iSinkRdy & tgt_oh) != 3'b000);
        accept = bus.iValid && ready;

        valid_d = valid_q & ~drain;
        for (int k = 0; k < 3; k++) begin
            data_d[k] = data_q[k];
        end

        if (accept) begin
            valid_d = valid_d | tgt_oh;
            for (int k = 0; k < 3; k++) begin
                if (tgt_oh[k]) begin
                    data_d[k] = bus.iData;
                end
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            valid_q <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 3; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Data registers keep their last word after draining; oValid alone qualifies them.
    assign bus.oReady = ready;
    assign bus.oValid = valid_q;
    assign bus.oData0 = data_q[0];
    assign bus.oData1 = data_q[1];
    assign bus.oData2 = data_q[2];
    assign bus.oBusy  = |valid_q;

endmodule
